// File: rtl/axis_merge_arbiter.sv
// Round-robin merge of S_COUNT AXI-Stream inputs into one registered output stream.
// Per-input terminator beats are absorbed; one merged terminator goes out once every input has closed.
module axis_merge_arbiter #(
    parameter int S_COUNT    = 4,
    parameter int DATA_WIDTH = 64
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          merge_enable,
    output logic                          merge_done,
    output logic [S_COUNT-1:0]            s_axis_tready,
    input  logic [S_COUNT*DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [S_COUNT-1:0]            s_axis_tlast,
    input  logic [S_COUNT-1:0]            s_axis_tvalid,
    input  logic                          m_axis_tready,
    output logic [DATA_WIDTH-1:0]         m_axis_tdata,
    output logic                          m_axis_tlast,
    output logic                          m_axis_tvalid
);

    localparam int PW = (S_COUNT > 1) ? $clog2(S_COUNT) : 1;

    typedef enum logic [1:0] {
        MERGE = 2'd0,
        TERM  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [S_COUNT-1:0]      done_q, done_d;
    logic [PW-1:0]           ptr_q, ptr_d;
    logic                    m_valid_q, m_valid_d;
    logic [DATA_WIDTH-1:0]   m_data_q, m_data_d;
    logic                    m_last_q, m_last_d;

    logic                    load_en;
    logic                    merge_ok;
    logic                    any_grant;
    logic                    accept;
    logic [S_COUNT-1:0]      elig;
    logic [S_COUNT-1:0]      grant;
    logic [PW-1:0]           sel_idx;
    logic [DATA_WIDTH-1:0]   sel_data;
    logic                    sel_last;

    assign load_en  = !m_valid_q || m_axis_tready;
    assign merge_ok = load_en && (state_q == MERGE);
    assign elig     = s_axis_tvalid & ~done_q;

    always_comb begin
        grant     = '0;
        any_grant = 1'b0;
        sel_idx   = '0;
        for (int k = 0; k < S_COUNT; k++) begin
            if (!any_grant && elig[(int'(ptr_q) + k) % S_COUNT]) begin
                grant[(int'(ptr_q) + k) % S_COUNT] = 1'b1;
                sel_idx   = PW'((int'(ptr_q) + k) % S_COUNT);
                any_grant = 1'b1;
            end
        end
    end

    // Pass-through uses input 0 directly, so its select is fixed rather than granted.
    always_comb begin
        if (merge_enable) begin
            sel_data = s_axis_tdata[sel_idx*DATA_WIDTH +: DATA_WIDTH];
            sel_last = s_axis_tlast[sel_idx];
        end else begin
            sel_data = s_axis_tdata[DATA_WIDTH-1:0];
            sel_last = s_axis_tlast[0];
        end
    end

    always_comb begin
        if (!rst_n) begin
            s_axis_tready = '0;
        end else if (merge_enable) begin
            s_axis_tready = grant & {S_COUNT{merge_ok}};
        end else begin
            s_axis_tready = {{(S_COUNT-1){1'b0}}, load_en};
        end
    end

    assign accept     = |(s_axis_tready & s_axis_tvalid);
    assign merge_done = merge_enable && (state_q == DRAIN) && m_valid_q && m_axis_tready;

    always_comb begin
        state_d   = state_q;
        done_d    = done_q;
        ptr_d     = ptr_q;
        m_valid_d = m_valid_q;
        m_data_d  = m_data_q;
        m_last_d  = m_last_q;

        if (m_valid_q && m_axis_tready) begin
            m_valid_d = 1'b0;
        end

        if (merge_enable) begin
            case (state_q)
                MERGE: begin
                    if (&done_q) begin
                        state_d = TERM;
                    end else if (accept) begin
                        ptr_d = (sel_idx == PW'(S_COUNT-1)) ? '0 : sel_idx + 1'b1;
                        if (sel_last) begin
                            done_d[sel_idx] = 1'b1;
                        end else begin
                            m_valid_d = 1'b1;
                            m_data_d  = sel_data;
                            m_last_d  = 1'b0;
                        end
                    end
                end
                // Waiting on load_en keeps the merged terminator behind any beat still in the register.
                TERM: begin
                    if (load_en) begin
                        m_valid_d = 1'b1;
                        m_data_d  = '1;
                        m_last_d  = 1'b1;
                        state_d   = DRAIN;
                    end
                end
                DRAIN: begin
                    if (m_valid_q && m_axis_tready) begin
                        done_d  = '0;
                        ptr_d   = '0;
                        state_d = MERGE;
                    end
                end
                default: begin
                    state_d = MERGE;
                end
            endcase
        end else if (accept) begin
            m_valid_d = 1'b1;
            m_data_d  = sel_data;
            m_last_d  = sel_last;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= MERGE;
            done_q    <= '0;
            ptr_q     <= '0;
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
            m_last_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            done_q    <= done_d;
            ptr_q     <= ptr_d;
            m_valid_q <= m_valid_d;
            m_data_q  <= m_data_d;
            m_last_q  <= m_last_d;
        end
    end

    assign m_axis_tvalid = m_valid_q;
    assign m_axis_tdata  = m_data_q;
    assign m_axis_tlast  = m_last_q;

endmodule

// File: tb/tb_axis_merge_arbiter.sv
// Directed self-checking bench for axis_merge_arbiter (S_COUNT=4, DATA_WIDTH=64).
// Inputs change on the falling edge; outputs are sampled 1 time unit after an edge.
module tb_axis_merge_arbiter;

    localparam int S = 4;
    localparam int W = 64;
    localparam logic [W-1:0] ONES = '1;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             merge_enable = 1'b1;
    logic             merge_done;
    logic [S-1:0]     s_axis_tready;
    logic [W-1:0]     in_data [S];
    logic [S*W-1:0]   s_axis_tdata;
    logic [S-1:0]     s_axis_tlast = '0;
    logic [S-1:0]     s_axis_tvalid = '0;
    logic             m_axis_tready = 1'b0;
    logic [W-1:0]     m_axis_tdata;
    logic             m_axis_tlast;
    logic             m_axis_tvalid;

    int total = 0;
    int bad = 0;
    int cnt [S];

    assign s_axis_tdata = {in_data[3], in_data[2], in_data[1], in_data[0]};

    axis_merge_arbiter #(.S_COUNT(S), .DATA_WIDTH(W)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .merge_enable  (merge_enable),
        .merge_done    (merge_done),
        .s_axis_tready (s_axis_tready),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tvalid (s_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tvalid (m_axis_tvalid)
    );

    always #5 clk = ~clk;

    // Random inputs while reset is held: every output and every ready must stay low.
    task automatic test_reset();
        rst_n = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            s_axis_tvalid = 4'($urandom());
            s_axis_tlast  = 4'($urandom());
            m_axis_tready = 1'($urandom());
            for (int i = 0; i < S; i++) in_data[i] = {$urandom(), $urandom()};
            #1;
            total++; if (m_axis_tvalid !== 1'b0) begin bad++; $display("[TB] FAIL reset_tvalid: got %b want 0", m_axis_tvalid); end
            total++; if (m_axis_tdata !== '0) begin bad++; $display("[TB] FAIL reset_tdata: got %h want 0", m_axis_tdata); end
            total++; if (m_axis_tlast !== 1'b0) begin bad++; $display("[TB] FAIL reset_tlast: got %b want 0", m_axis_tlast); end
            total++; if (merge_done !== 1'b0) begin bad++; $display("[TB] FAIL reset_done: got %b want 0", merge_done); end
            total++; if (s_axis_tready !== 4'b0000) begin bad++; $display("[TB] FAIL reset_tready: got %b want 0000", s_axis_tready); end
        end
        @(negedge clk);
        s_axis_tvalid = '0;
        s_axis_tlast  = '0;
        m_axis_tready = 1'b1;
        for (int i = 0; i < S; i++) in_data[i] = '0;
        rst_n = 1'b1;
    endtask

    // All inputs always valid: expect grants 0,1,2,3,0,... and data 0x10*i+n one cycle later.
    task automatic test_round_robin();
        logic [S-1:0] exp_rdy;
        logic [W-1:0] exp_dat;
        int g;
        for (int i = 0; i < S; i++) cnt[i] = 0;
        for (int b = 0; b < 8; b++) begin
            g = b % S;
            @(negedge clk);
            s_axis_tvalid = 4'b1111;
            s_axis_tlast  = 4'b0000;
            for (int i = 0; i < S; i++) in_data[i] = 64'(16 * i + cnt[i]);
            #1;
            if (b == 0) begin
                total++; if (m_axis_tvalid !== 1'b0) begin bad++; $display("[TB] FAIL rr_idle_before_first: got %b want 0", m_axis_tvalid); end
            end
            exp_rdy = 4'(1 << g);
            total++; if (s_axis_tready !== exp_rdy) begin bad++; $display("[TB] FAIL rr_grant beat %0d: got %b want %b", b, s_axis_tready, exp_rdy); end
            @(posedge clk); #1;
            exp_dat = 64'(16 * g + cnt[g]);
            cnt[g]++;
            total++; if (m_axis_tvalid !== 1'b1) begin bad++; $display("[TB] FAIL rr_tvalid beat %0d: got %b want 1", b, m_axis_tvalid); end
            total++; if (m_axis_tdata !== exp_dat) begin bad++; $display("[TB] FAIL rr_tdata beat %0d: got %h want %h", b, m_axis_tdata, exp_dat); end
            total++; if (m_axis_tlast !== 1'b0) begin bad++; $display("[TB] FAIL rr_tlast beat %0d: got %b want 0", b, m_axis_tlast); end
        end
        @(negedge clk);
        s_axis_tvalid = '0;
        @(posedge clk); #1;
        total++; if (m_axis_tvalid !== 1'b0) begin bad++; $display("[TB] FAIL rr_drain: got %b want 0", m_axis_tvalid); end
    endtask

    // Three-cycle downstream stall after the first beat: register holds, nothing is granted.
    task automatic test_backpressure();
        logic         rdy_t [7] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        logic [S-1:0] trdy_t [7] = '{4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0010, 4'b0100, 4'b1000};
        logic [W-1:0] dat_t [7] = '{64'h02, 64'h02, 64'h02, 64'h02, 64'h12, 64'h22, 64'h32};
        for (int s = 0; s < 7; s++) begin
            @(negedge clk);
            m_axis_tready = rdy_t[s];
            s_axis_tvalid = 4'b1111;
            for (int i = 0; i < S; i++) in_data[i] = 64'(16 * i + cnt[i]);
            #1;
            total++; if (s_axis_tready !== trdy_t[s]) begin bad++; $display("[TB] FAIL bp_tready step %0d: got %b want %b", s, s_axis_tready, trdy_t[s]); end
            @(posedge clk); #1;
            for (int i = 0; i < S; i++) if (trdy_t[s][i]) cnt[i]++;
            total++; if (m_axis_tvalid !== 1'b1) begin bad++; $display("[TB] FAIL bp_tvalid step %0d: got %b want 1", s, m_axis_tvalid); end
            total++; if (m_axis_tdata !== dat_t[s]) begin bad++; $display("[TB] FAIL bp_tdata step %0d: got %h want %h", s, m_axis_tdata, dat_t[s]); end
        end
        @(negedge clk);
        s_axis_tvalid = '0;
        m_axis_tready = 1'b1;
        @(posedge clk); #1;
        total++; if (m_axis_tvalid !== 1'b0) begin bad++; $display("[TB] FAIL bp_drain: got %b want 0", m_axis_tvalid); end
    endtask

    // Inputs send 2,1,3,0 data beats, then terminators 3,1,0,2; one merged terminator follows.
    task automatic test_terminators();
        int           src_t [10] = '{0, 1, 2, 0, 2, 2, 3, 1, 0, 2};
        logic         lst_t [10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        logic [W-1:0] dat_t [10] = '{64'hA0, 64'hB0, 64'hC0, 64'hA1, 64'hC1, 64'hC2, ONES, ONES, ONES, ONES};
        logic [S-1:0] exp_rdy;
        int           nbeats = 0;
        for (int s = 0; s < 10; s++) begin
            @(negedge clk);
            s_axis_tvalid = '0;
            s_axis_tlast  = '0;
            s_axis_tvalid[src_t[s]] = 1'b1;
            s_axis_tlast[src_t[s]]  = lst_t[s];
            in_data[src_t[s]]       = dat_t[s];
            #1;
            exp_rdy = 4'(1 << src_t[s]);
            total++; if (s_axis_tready !== exp_rdy) begin bad++; $display("[TB] FAIL term_tready step %0d: got %b want %b", s, s_axis_tready, exp_rdy); end
            total++; if (merge_done !== 1'b0) begin bad++; $display("[TB] FAIL term_early_done step %0d: got %b want 0", s, merge_done); end
            @(posedge clk); #1;
            if (m_axis_tvalid === 1'b1 && m_axis_tlast === 1'b0) nbeats++;
            if (!lst_t[s]) begin
                total++; if (m_axis_tdata !== dat_t[s]) begin bad++; $display("[TB] FAIL term_data step %0d: got %h want %h", s, m_axis_tdata, dat_t[s]); end
            end else begin
                total++; if (m_axis_tvalid !== 1'b0) begin bad++; $display("[TB] FAIL term_absorbed step %0d: got tvalid %b want 0", s, m_axis_tvalid); end
            end
        end
        total++; if (nbeats !== 6) begin bad++; $display("[TB] FAIL term_beat_count: got %0d want 6", nbeats); end

        // Input 1 offers a fresh beat early; it must wait until the merge completes.
        @(negedge clk);
        s_axis_tvalid = 4'b0010;
        s_axis_tlast  = 4'b0000;
        in_data[1]    = 64'hB1;
        #1;
        total++; if (s_axis_tready !== 4'b0000) begin bad++; $display("[TB] FAIL term_holdoff_merge: got %b want 0000", s_axis_tready); end
        @(posedge clk); #1;
        total++; if (m_axis_tvalid !== 1'b0) begin bad++; $display("[TB] FAIL term_gap: got %b want 0", m_axis_tvalid); end
        @(negedge clk); #1;
        total++; if (s_axis_tready !== 4'b0000) begin bad++; $display("[TB] FAIL term_holdoff_term: got %b want 0000", s_axis_tready); end
        @(posedge clk); #1;
        total++; if (m_axis_tvalid !== 1'b1) begin bad++; $display("[TB] FAIL term_out_valid: got %b want 1", m_axis_tvalid); end
        total++; if (m_axis_tdata !== ONES) begin bad++; $display("[TB] FAIL term_out_data: got %h want %h", m_axis_tdata, ONES); end
        total++; if (m_axis_tlast !== 1'b1) begin bad++; $display("[TB] FAIL term_out_last: got %b want 1", m_axis_tlast); end
        @(negedge clk); #1;
        total++; if (merge_done !== 1'b1) begin bad++; $display("[TB] FAIL term_done_pulse: got %b want 1", merge_done); end
        total++; if (s_axis_tready !== 4'b0000) begin bad++; $display("[TB] FAIL term_holdoff_drain: got %b want 0000", s_axis_tready); end
        @(posedge clk); #1;
        total++; if (m_axis_tvalid !== 1'b0) begin bad++; $display("[TB] FAIL term_after_drain: got %b want 0", m_axis_tvalid); end
        @(negedge clk); #1;
        total++; if (merge_done !== 1'b0) begin bad++; $display("[TB] FAIL term_done_width: got %b want 0", merge_done); end
        total++; if (s_axis_tready !== 4'b0010) begin bad++; $display("[TB] FAIL term_resume_tready: got %b want 0010", s_axis_tready); end
        @(posedge clk); #1;
        total++; if (m_axis_tdata !== 64'hB1 || m_axis_tvalid !== 1'b1) begin bad++; $display("[TB] FAIL term_resume_data: got %h/%b want b1/1", m_axis_tdata, m_axis_tvalid); end
        @(negedge clk);
        s_axis_tvalid = '0;
        @(posedge clk); #1;
    endtask

    // merge_enable=0: only input 0 is forwarded, tlast included, and no terminator is built.
    task automatic test_pass_through();
        @(negedge clk);
        merge_enable  = 1'b0;
        s_axis_tvalid = 4'b1111;
        s_axis_tlast  = 4'b0000;
        for (int i = 1; i < S; i++) in_data[i] = 64'h55;
        in_data[0] = 64'hAB;
        #1;
        total++; if (s_axis_tready !== 4'b0001) begin bad++; $display("[TB] FAIL pt_tready_first: got %b want 0001", s_axis_tready); end
        @(posedge clk); #1;
        total++; if (m_axis_tdata !== 64'hAB || m_axis_tlast !== 1'b0) begin bad++; $display("[TB] FAIL pt_first: got %h/%b want ab/0", m_axis_tdata, m_axis_tlast); end
        @(negedge clk);
        in_data[0]   = 64'hCD;
        s_axis_tlast = 4'b0001;
        #1;
        total++; if (s_axis_tready !== 4'b0001) begin bad++; $display("[TB] FAIL pt_tready_second: got %b want 0001", s_axis_tready); end
        @(posedge clk); #1;
        total++; if (m_axis_tdata !== 64'hCD || m_axis_tlast !== 1'b1 || m_axis_tvalid !== 1'b1) begin bad++; $display("[TB] FAIL pt_second: got %h/%b/%b want cd/1/1", m_axis_tdata, m_axis_tlast, m_axis_tvalid); end
        total++; if (merge_done !== 1'b0) begin bad++; $display("[TB] FAIL pt_no_done: got %b want 0", merge_done); end
        @(negedge clk);
        s_axis_tvalid = 4'b1110;
        s_axis_tlast  = 4'b0000;
        #1;
        total++; if (s_axis_tready[3:1] !== 3'b000) begin bad++; $display("[TB] FAIL pt_others_blocked: got %b want 000", s_axis_tready[3:1]); end
        @(posedge clk); #1;
        total++; if (m_axis_tvalid !== 1'b0 || merge_done !== 1'b0) begin bad++; $display("[TB] FAIL pt_idle: got valid %b done %b want 0/0", m_axis_tvalid, merge_done); end
        @(negedge clk);
        s_axis_tvalid = '0;
        merge_enable  = 1'b1;
    endtask

    // Reset between edges with a held beat and done=0101; afterwards all four terminators are needed.
    task automatic test_async_reset();
        int           src_t [4] = '{1, 3, 0, 2};
        logic [S-1:0] exp_rdy;
        // Pointer is 2 here: terminator from 0 (only eligible), then 2, then a data beat from 1.
        @(negedge clk);
        s_axis_tvalid = 4'b0001; s_axis_tlast = 4'b0001; in_data[0] = ONES;
        @(negedge clk);
        s_axis_tvalid = 4'b0100; s_axis_tlast = 4'b0100; in_data[2] = ONES;
        @(negedge clk);
        s_axis_tvalid = 4'b0010; s_axis_tlast = 4'b0000; in_data[1] = 64'h77;
        @(posedge clk); #1;
        total++; if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 64'h77) begin bad++; $display("[TB] FAIL ar_held: got %b/%h want 1/77", m_axis_tvalid, m_axis_tdata); end
        m_axis_tready = 1'b0;
        s_axis_tvalid = 4'b1111;
        #1;
        rst_n = 1'b0;
        #1;
        total++; if (m_axis_tvalid !== 1'b0) begin bad++; $display("[TB] FAIL ar_tvalid_async: got %b want 0", m_axis_tvalid); end
        total++; if (m_axis_tdata !== '0) begin bad++; $display("[TB] FAIL ar_tdata_async: got %h want 0", m_axis_tdata); end
        total++; if (s_axis_tready !== 4'b0000) begin bad++; $display("[TB] FAIL ar_tready_async: got %b want 0000", s_axis_tready); end
        @(negedge clk);
        rst_n = 1'b1;
        m_axis_tready = 1'b1;
        s_axis_tvalid = '0;
        for (int s = 0; s < 4; s++) begin
            @(negedge clk);
            s_axis_tvalid = '0;
            s_axis_tlast  = '0;
            s_axis_tvalid[src_t[s]] = 1'b1;
            s_axis_tlast[src_t[s]]  = 1'b1;
            in_data[src_t[s]]       = ONES;
            #1;
            exp_rdy = 4'(1 << src_t[s]);
            total++; if (s_axis_tready !== exp_rdy) begin bad++; $display("[TB] FAIL ar_term_tready step %0d: got %b want %b", s, s_axis_tready, exp_rdy); end
            if (s == 1) begin
                // Only inputs 1 and 3 have closed since reset: no merged terminator may appear.
                @(negedge clk);
                s_axis_tvalid = '0;
                @(negedge clk);
                @(posedge clk); #1;
                total++; if (m_axis_tvalid !== 1'b0) begin bad++; $display("[TB] FAIL ar_done_cleared: got %b want 0", m_axis_tvalid); end
            end
        end
        @(negedge clk);
        s_axis_tvalid = '0;
        @(posedge clk); #1;
        total++; if (m_axis_tvalid !== 1'b0) begin bad++; $display("[TB] FAIL ar_term_gap: got %b want 0", m_axis_tvalid); end
        @(posedge clk); #1;
        total++; if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== ONES || m_axis_tlast !== 1'b1) begin bad++; $display("[TB] FAIL ar_term_out: got %b/%h/%b want 1/%h/1", m_axis_tvalid, m_axis_tdata, m_axis_tlast, ONES); end
        @(negedge clk); #1;
        total++; if (merge_done !== 1'b1) begin bad++; $display("[TB] FAIL ar_done_pulse: got %b want 1", merge_done); end
        @(posedge clk); #1;
        total++; if (m_axis_tvalid !== 1'b0) begin bad++; $display("[TB] FAIL ar_final_drain: got %b want 0", m_axis_tvalid); end
        @(negedge clk); #1;
        total++; if (merge_done !== 1'b0) begin bad++; $display("[TB] FAIL ar_done_width: got %b want 0", merge_done); end
    endtask

    initial begin
        for (int i = 0; i < S; i++) in_data[i] = '0;
        test_reset();
        test_round_robin();
        test_backpressure();
        test_terminators();
        test_pass_through();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/axis_merge_arbiter.md
Name: axis_merge_arbiter

Overview:
- Merges S_COUNT AXI-Stream inputs into one output stream, with round-robin arbitration between inputs.
- Receive-side counterpart of the fork stage. Each input is closed by a terminator beat (tlast=1, data all ones).
- Terminator beats are consumed and not forwarded. Once every input has terminated, the block emits exactly one all-ones tlast beat downstream and pulses merge_done.
- Sits between the per-core output channels and the single return DMA stream.

Parameters:
S_COUNT, 4, number of input streams (>=2)
DATA_WIDTH, 64, beat width in bits

Ports:
clk  input  1  clock
rst_n  input  1  reset, asynchronous, active-low
merge_enable  input  1  1 = arbitrated merge with terminator handling; 0 = pass-through of input 0 only
merge_done  output  1  one-cycle pulse when the merged terminator beat is accepted downstream
s_axis_tready  output  S_COUNT  per-input ready
s_axis_tdata  input  S_COUNT*DATA_WIDTH  input i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
s_axis_tlast  input  S_COUNT  per-input last/terminator flag
s_axis_tvalid  input  S_COUNT  per-input valid
m_axis_tready  input  1  downstream ready
m_axis_tdata  output  DATA_WIDTH  merged data
m_axis_tlast  output  1  merged last
m_axis_tvalid  output  1  merged valid

Behaviour:
- Clocking and reset: one clock, clk. rst_n is asynchronous and active-low.
- Reset state, applied immediately on rst_n low without waiting for a clock edge:
  - m_axis_tvalid=0, m_axis_tdata=0, m_axis_tlast=0, merge_done=0
  - all done flags=0, round-robin pointer=0, state=MERGE
  - s_axis_tready is combinational and therefore 0 while in reset
  - any in-flight beat is discarded
- Output register: a single registered stage drives m_axis_*. It may load when load_en = !m_axis_tvalid || m_axis_tready. Latency from input acceptance to m_axis_tvalid is 1 cycle. At most one load per cycle, so full throughput is 1 beat/cycle.
- m_axis_tvalid never depends combinationally on m_axis_tready. m_axis_tdata and m_axis_tlast hold stable while m_axis_tvalid=1 and m_axis_tready=0.
- Eligibility: elig[i] = s_axis_tvalid[i] && !done[i].
- Grant: one-hot, selecting the first eligible index searching upward from the pointer with wrap-around. No grant if there are no eligible inputs.
- Readiness: s_axis_tready = grant && {S_COUNT{load_en && state==MERGE}}. s_axis_tready may depend on s_axis_tvalid.
- State MERGE, on an accepted beat from input i:
  - If tlast=0: load its data, with m_axis_tlast=0, into the output register.
  - If tlast=1: set done[i] and load nothing. Data content is ignored; all ones is expected.
  - In both cases, set pointer = (i+1) mod S_COUNT.
- Transition MERGE -> TERM occurs in the cycle after done becomes all ones.
- Inputs whose done flag is set see tready=0 until the merge completes.
- State TERM:
  - When load_en=1, load tdata = all ones and tlast=1, then move to DRAIN.
  - No input is granted.
- State DRAIN:
  - When m_axis_tvalid && m_axis_tready, pulse merge_done=1 for exactly that cycle.
  - In the same cycle: clear all done flags, set pointer=0, and return to MERGE.
  - A new input beat may be accepted on the following cycle.
- merge_enable=0 (pass-through):
  - s_axis_tready[0] = load_en; s_axis_tready[S_COUNT-1:1] = 0.
  - Input 0 beats, tlast included, are forwarded unchanged.
  - done flags, the pointer and the state machine do not update. No terminator is generated and merge_done stays 0.
- merge_enable may change only when the block is quiescent (state MERGE, done=0, m_axis_tvalid=0). Changing it at any other time must not corrupt a beat already held in the output register; all other effects are unspecified.
- Simultaneous events:
  - A downstream handshake and a new load in the same cycle: the register is replaced with no bubble.
  - The last input terminator and a pending data beat in the register: TERM waits for load_en, so ordering is preserved and the terminator always goes out last.
- Boundary conditions:
  - An input that sends tlast on its first beat contributes zero data beats.
  - The pointer wraps from S_COUNT-1 to 0.

Test Plan:
- Reset: hold rst_n=0 with random inputs -> m_axis_tvalid=0, m_axis_tdata=0, m_axis_tlast=0, merge_done=0, s_axis_tready=0.
- Round-robin: S_COUNT=4, merge_enable=1, all inputs continuously valid (input i sends 0x10*i+n), m_axis_tready=1 -> output order inputs 0,1,2,3,0,1..., one beat/cycle, first m_axis_tvalid one cycle after the first s handshake.
- Backpressure: drop m_axis_tready for 3 cycles mid-stream -> m_axis_tdata stable, s_axis_tready=0, no beat lost or duplicated once ready returns.
- Terminators: inputs 0..3 send 2,1,3,0 data beats, then tlast terminators in order 3,1,0,2 -> exactly 6 data beats with tlast=0, then one beat 0xFFFF_FFFF_FFFF_FFFF with tlast=1; merge_done high for one cycle on its handshake; a new input-1 beat presented early is held off (tready=0) until after merge_done.
- Pass-through: merge_enable=0, input 0 sends 0xAB then 0xCD with tlast=1, inputs 1-3 valid -> output 0xAB, then 0xCD with tlast=1; s_axis_tready[3:1]=0 throughout; merge_done never asserts.
- Async reset mid-operation: assert rst_n=0 between clock edges while m_axis_tvalid=1 and done=4'b0101 -> m_axis_tvalid falls immediately; after release, a full terminator sequence still requires terminators from all four inputs.
